// File: rtl/timer_alarm_pkg.sv
// Shared constants for the timer alarm block: register map, CTRL/STATUS bit
// positions, MISSED counter width, FSM state type and a saturating helper.
package timer_alarm_pkg;

  // Register map (3-bit word address)
  localparam logic [2:0] ADDR_CMP_LO = 3'd0;
  localparam logic [2:0] ADDR_CMP_HI = 3'd1;
  localparam logic [2:0] ADDR_PER_LO = 3'd2;
  localparam logic [2:0] ADDR_PER_HI = 3'd3;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_MISSED = 3'd6;
  localparam logic [2:0] ADDR_RSVD   = 3'd7;

  // Bit positions inside CTRL and STATUS
  localparam int CTRL_ARM_BIT      = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int STATUS_FIRED_BIT  = 0;

  // Width of the missed-hit counter
  localparam int MISSED_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } alarm_state_e;

  // Increment that sticks at all-ones
  function automatic logic [MISSED_W-1:0] sat_inc(input logic [MISSED_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/timer_alarm_cmp.sv
// Full-width unsigned compare of the running count against the alarm value,
// plus the next periodic alarm value (CMP+PER, wrapping modulo 2^CNT_W).
module timer_alarm_cmp #(
  parameter int CNT_W = 64
) (
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_cmp,
  input  logic [CNT_W-1:0] i_per,
  output logic             o_ge,
  output logic             o_per_nz,
  output logic [CNT_W-1:0] o_next_cmp
);

  assign o_ge       = (i_cnt >= i_cmp);
  assign o_per_nz   = |i_per;
  // Natural truncation of the adder gives the modulo wrap.
  assign o_next_cmp = i_cmp + i_per;

endmodule

// File: rtl/timer_alarm.sv
// Alarm peripheral: CPU register interface, LO-word shadows for atomic 64-bit
// updates, IDLE/ARMED FSM, FIRED flag (drives irq) and saturating MISSED count.
//
// Handshake: every cycle with valid=1 is one request. It is answered by ready=1
// on the following cycle, with rdata holding the register contents as they
// were during the valid cycle. A write is applied at the same clock edge, so
// its new value is already visible during the ready cycle. Holding valid high
// issues one request per cycle. rst drops any request in flight (no ready).
module timer_alarm
  import timer_alarm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*DATA_W-1:0]   timer_cnt,
  input  logic                  valid,
  input  logic [2:0]            address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic                  irq
);

  localparam int CNT_W = 2 * DATA_W;

  alarm_state_e         r_state;
  logic [CNT_W-1:0]     r_cmp;
  logic [CNT_W-1:0]     r_per;
  logic [DATA_W-1:0]    r_cmp_lo_sh;
  logic [DATA_W-1:0]    r_per_lo_sh;
  logic                 r_periodic;
  logic                 r_fired;
  logic [MISSED_W-1:0]  r_missed;
  logic                 r_ready;
  logic [DATA_W-1:0]    r_rdata;

  logic                 w_wr;
  logic                 w_wr_cmp_lo;
  logic                 w_wr_cmp_hi;
  logic                 w_wr_per_lo;
  logic                 w_wr_per_hi;
  logic                 w_wr_ctrl;
  logic                 w_ack;
  logic                 w_ge;
  logic                 w_per_nz;
  logic [CNT_W-1:0]     w_next_cmp;
  logic                 w_hit;
  logic                 w_reload;
  logic [DATA_W-1:0]    w_rd;

  // Request decode: any strobe bit set means write
  assign w_wr        = valid && (|wstrb);
  assign w_wr_cmp_lo = w_wr && (address == ADDR_CMP_LO);
  assign w_wr_cmp_hi = w_wr && (address == ADDR_CMP_HI);
  assign w_wr_per_lo = w_wr && (address == ADDR_PER_LO);
  assign w_wr_per_hi = w_wr && (address == ADDR_PER_HI);
  assign w_wr_ctrl   = w_wr && (address == ADDR_CTRL);
  assign w_ack       = w_wr && (address == ADDR_STATUS) && wdata[STATUS_FIRED_BIT];

  timer_alarm_cmp #(
    .CNT_W(CNT_W)
  ) u_cmp (
    .i_cnt      (timer_cnt),
    .i_cmp      (r_cmp),
    .i_per      (r_per),
    .o_ge       (w_ge),
    .o_per_nz   (w_per_nz),
    .o_next_cmp (w_next_cmp)
  );

  assign w_hit    = (r_state == ST_ARMED) && w_ge;
  // A periodic alarm with a zero period behaves as one-shot.
  assign w_reload = w_hit && r_periodic && w_per_nz;

  // Read mux: committed register state seen during the valid cycle
  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_CMP_LO: w_rd = r_cmp[DATA_W-1:0];
      ADDR_CMP_HI: w_rd = r_cmp[CNT_W-1:DATA_W];
      ADDR_PER_LO: w_rd = r_per[DATA_W-1:0];
      ADDR_PER_HI: w_rd = r_per[CNT_W-1:DATA_W];
      ADDR_CTRL: begin
        w_rd[CTRL_ARM_BIT]      = (r_state == ST_ARMED);
        w_rd[CTRL_PERIODIC_BIT] = r_periodic;
      end
      ADDR_STATUS: w_rd[STATUS_FIRED_BIT] = r_fired;
      ADDR_MISSED: w_rd[MISSED_W-1:0]     = r_missed;
      default:     w_rd = '0;
    endcase
  end

  // Bus response: one ready per valid cycle, read data captured with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= valid;
      r_rdata <= valid ? w_rd : '0;
    end
  end

  // LO-word shadows; they only reach CMP/PER when the HI word is written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmp_lo_sh <= '0;
      r_per_lo_sh <= '0;
    end else begin
      if (w_wr_cmp_lo) r_cmp_lo_sh <= wdata;
      if (w_wr_per_lo) r_per_lo_sh <= wdata;
    end
  end

  // Alarm value and period: atomic HI commit, CPU commit beats periodic reload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmp <= '0;
      r_per <= '0;
    end else begin
      if (w_wr_cmp_hi)   r_cmp <= {wdata, r_cmp_lo_sh};
      else if (w_reload) r_cmp <= w_next_cmp;
      if (w_wr_per_hi)   r_per <= {wdata, r_per_lo_sh};
    end
  end

  // Arm FSM: CTRL writes set the state; a non-reloading hit disarms
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_periodic <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_periodic <= wdata[CTRL_PERIODIC_BIT];
      case (r_state)
        ST_IDLE: begin
          if (w_wr_ctrl && wdata[CTRL_ARM_BIT]) r_state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (w_wr_ctrl)                 r_state <= wdata[CTRL_ARM_BIT] ? ST_ARMED : ST_IDLE;
          else if (w_hit && !w_reload)   r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // FIRED / MISSED: a hit outranks an ack; an ack clears MISSED outright
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fired  <= 1'b0;
      r_missed <= '0;
    end else begin
      if (w_hit)      r_fired <= 1'b1;
      else if (w_ack) r_fired <= 1'b0;
      if (w_ack)                r_missed <= '0;
      else if (w_hit && r_fired) r_missed <= sat_inc(r_missed);
    end
  end

  assign ready = r_ready;
  assign rdata = r_rdata;
  assign irq   = r_fired;

endmodule

// File: tb/tb_timer_alarm.sv
// Directed bench for timer_alarm: inputs change on the falling edge, outputs
// are checked on the falling edge, every expected value is hand-derived.
module tb_timer_alarm;
  import timer_alarm_pkg::*;

  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic [63:0]       timer_cnt;
  logic              valid;
  logic [2:0]        address;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic [31:0]       rdata;
  logic              ready;
  logic              irq;

  int n_checks = 0;
  int n_fail   = 0;

  timer_alarm #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .timer_cnt (timer_cnt),
    .valid     (valid),
    .address   (address),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .rdata     (rdata),
    .ready     (ready),
    .irq       (irq)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus tasks: called on a falling edge, return on the next falling edge
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    valid   = 1'b1;
    address = a;
    wdata   = d;
    wstrb   = 4'hF;
    @(negedge clk);
    check("wr_ready", ready, 1);
    valid = 1'b0;
    wstrb = 4'h0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
    valid   = 1'b1;
    address = a;
    wstrb   = 4'h0;
    @(negedge clk);
    check("rd_ready", ready, 1);
    check(tag, rdata, exp);
    valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    timer_cnt = '0;
    valid     = 1'b0;
    address   = '0;
    wdata     = '0;
    wstrb     = '0;

    // Reset state
    @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_irq",   irq,   0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // One-shot alarm at 100
    bus_write(ADDR_CMP_LO, 32'd100);
    bus_write(ADDR_CMP_HI, 32'd0);
    bus_write(ADDR_CTRL,   32'd1);
    bus_read(ADDR_CTRL, 32'd1, "ctrl_armed");
    for (int k = 1; k <= 101; k++) begin
      timer_cnt = 64'(k);
      @(negedge clk);
      check("irq_oneshot", irq, (k >= 100));
    end
    check("ready_idle", ready, 0);
    bus_read(ADDR_CTRL,   32'd0, "ctrl_after_oneshot");
    bus_read(ADDR_STATUS, 32'd1, "status_fired");
    bus_read(ADDR_MISSED, 32'd0, "missed_oneshot");
    bus_write(ADDR_STATUS, 32'd0);
    bus_read(ADDR_STATUS, 32'd1, "status_write0_noeffect");
    bus_write(ADDR_STATUS, 32'd1);
    check("irq_acked", irq, 0);

    // LO-only write stays in the shadow until HI is written
    timer_cnt = 64'd0;
    bus_write(ADDR_CMP_LO, 32'd50);
    bus_read(ADDR_CMP_LO, 32'd100, "cmp_lo_committed");
    bus_write(ADDR_CTRL, 32'd1);
    for (int k = 1; k <= 60; k++) begin
      timer_cnt = 64'(k);
      @(negedge clk);
      check("irq_shadow_only", irq, 0);
    end
    bus_write(ADDR_CMP_HI, 32'd0);
    check("irq_before_commit_hit", irq, 0);
    @(negedge clk);
    check("irq_commit_below", irq, 1);
    bus_read(ADDR_CMP_LO, 32'd50, "cmp_lo_after_commit");
    bus_read(ADDR_CTRL, 32'd0, "ctrl_after_commit_hit");
    bus_write(ADDR_STATUS, 32'd1);

    // Periodic 10/10 without ack: hits at 10,20,30,40
    timer_cnt = 64'd0;
    bus_write(ADDR_CMP_LO, 32'd10);
    bus_write(ADDR_CMP_HI, 32'd0);
    bus_write(ADDR_PER_LO, 32'd10);
    bus_write(ADDR_PER_HI, 32'd0);
    bus_write(ADDR_CTRL,   32'd3);
    for (int k = 1; k <= 45; k++) begin
      timer_cnt = 64'(k);
      @(negedge clk);
      check("irq_periodic", irq, (k >= 10));
    end
    bus_read(ADDR_MISSED, 32'd3,  "missed_periodic");
    bus_read(ADDR_CMP_LO, 32'd50, "cmp_lo_periodic");
    bus_read(ADDR_CMP_HI, 32'd0,  "cmp_hi_periodic");
    bus_read(ADDR_PER_LO, 32'd10, "per_lo");
    bus_read(ADDR_CTRL,   32'd3,  "ctrl_periodic");

    // Ack on the same edge as a hit (CMP=50)
    timer_cnt = 64'd50;
    bus_write(ADDR_STATUS, 32'd1);
    check("irq_ack_vs_hit", irq, 1);
    bus_read(ADDR_STATUS, 32'd1,  "status_ack_vs_hit");
    bus_read(ADDR_MISSED, 32'd0,  "missed_ack_vs_hit");
    bus_read(ADDR_CMP_LO, 32'd60, "cmp_after_ack_hit");

    // CMP writes keep state; disarm keeps FIRED; reserved register
    bus_write(ADDR_CMP_LO, 32'd200);
    bus_write(ADDR_CMP_HI, 32'd0);
    bus_read(ADDR_CTRL, 32'd3, "ctrl_after_cmp_write");
    bus_write(ADDR_CTRL, 32'd0);
    bus_read(ADDR_CTRL,   32'd0, "ctrl_disarmed");
    bus_read(ADDR_STATUS, 32'd1, "status_after_disarm");
    bus_write(ADDR_RSVD, 32'hDEAD_BEEF);
    bus_read(ADDR_RSVD, 32'd0, "reserved_reads_zero");
    bus_write(ADDR_STATUS, 32'd1);
    check("irq_acked2", irq, 0);

    // Periodic reload wrapping past 2^64-1
    bus_write(ADDR_CMP_LO, 32'hFFFF_FFF8);
    bus_write(ADDR_CMP_HI, 32'hFFFF_FFFF);
    bus_write(ADDR_PER_LO, 32'd16);
    bus_write(ADDR_PER_HI, 32'd0);
    bus_write(ADDR_CTRL,   32'd3);
    bus_read(ADDR_CMP_HI, 32'hFFFF_FFFF, "cmp_hi_big");
    check("irq_before_wrap", irq, 0);
    timer_cnt = 64'hFFFF_FFFF_FFFF_FFF8;
    @(negedge clk);
    check("irq_wrap_hit", irq, 1);
    timer_cnt = 64'd0;
    bus_read(ADDR_CMP_LO, 32'd8, "cmp_lo_wrapped");
    bus_read(ADDR_CMP_HI, 32'd0, "cmp_hi_wrapped");
    bus_read(ADDR_MISSED, 32'd0, "missed_wrap_first");
    timer_cnt = 64'hFFFF_FFFF_FFFF_FFF9;
    @(negedge clk);
    timer_cnt = 64'd0;
    bus_read(ADDR_MISSED, 32'd1,  "missed_wrap_second");
    bus_read(ADDR_CMP_LO, 32'd24, "cmp_lo_second_reload");
    check("irq_still_set", irq, 1);

    // Reset while armed, fired, and with a read in flight
    valid   = 1'b1;
    address = ADDR_CMP_LO;
    wstrb   = 4'h0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_abort_ready", ready, 0);
    check("rst_abort_irq",   irq,   0);
    check("rst_abort_rdata", rdata, 0);
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("no_late_ready", ready, 0);
    valid = 1'b1;
    wstrb = 4'h0;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      @(negedge clk);
      check("b2b_ready", ready, 1);
      check("post_rst_reg", rdata, 0);
    end
    valid = 1'b0;
    @(negedge clk);
    check("b2b_ready_drop", ready, 0);
    check("post_rst_irq", irq, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
